// File: rtl/tmc_spi_pkg.sv
// tmc_spi_pkg: shared types for the TMC5130 register sequencer.
// Datagram layout, FSM state codes and counter sizing.
package tmc_spi_pkg;

    localparam int TMC_DGRAM_W = 40;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] data;
    } tmc_dgram_t;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_LOAD    = 3'd1,
        SEQ_WAIT_RX = 3'd2,
        SEQ_GAP     = 3'd3,
        SEQ_RESP    = 3'd4
    } tmc_seq_state_e;

    // Wide enough for the timeout count and any gap count up to 255.
    function automatic int tmc_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/tmc_spi_frame_timer.sv
// tmc_spi_frame_timer: loadable down-counter with enable.
// done flags the enabled cycle on which the count runs out.
module tmc_spi_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = en && (count == W'(1));

endmodule

// File: rtl/tmc_spi_sequencer.sv
// tmc_spi_sequencer: TMC5130 register access over the 40-bit SPI master.
// Define TMC_SPI_TIMEOUT_EN to build the ack/valid timeout abort.
module tmc_spi_sequencer
    import tmc_spi_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                   pclk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [6:0]             req_addr_i,
    input  logic [31:0]            req_data_i,
    output logic                   rsp_valid_o,
    output logic [7:0]             rsp_status_o,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_error_o,
    output logic                   busy_o,
    output logic [TMC_DGRAM_W-1:0] spi_di_o,
    output logic                   spi_wren_o,
    input  logic                   spi_wr_ack_i,
    input  logic                   spi_do_valid_i,
    input  logic [TMC_DGRAM_W-1:0] spi_do_i,
    input  logic                   spi_idle_i
);

    localparam logic [2:0] S_IDLE = SEQ_IDLE;
    localparam logic [2:0] S_LOAD = SEQ_LOAD;
    localparam logic [2:0] S_WAIT = SEQ_WAIT_RX;
    localparam logic [2:0] S_GAP  = SEQ_GAP;
    localparam logic [2:0] S_RESP = SEQ_RESP;

    localparam int CW = tmc_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES);
`ifdef TMC_SPI_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES);
`endif

    logic [2:0]    state;
    logic [2:0]    state_nx;
    tmc_dgram_t    dgram;
    logic          phase;
    logic [7:0]    rsp_status;
    logic [31:0]   rsp_data;
    logic          accept;
    logic          resend;
    logic          abort;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_done;
`ifdef TMC_SPI_TIMEOUT_EN
    logic          timeout;
`endif

    assign accept = (state == S_IDLE) && req_valid_i;
    // Reads go out twice: the chip answers on the following frame.
    assign resend = !dgram.wr && !phase && !abort;

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = GAP_LD;
        tmr_en   = 1'b0;
`ifdef TMC_SPI_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (req_valid_i) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (spi_wr_ack_i) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (spi_do_valid_i) state_nx = S_GAP;
            end
            S_GAP: begin
                tmr_en   = spi_idle_i;
                tmr_load = !spi_idle_i;
                if (tmr_done) state_nx = resend ? S_LOAD : S_RESP;
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
`ifdef TMC_SPI_TIMEOUT_EN
        if (state == S_LOAD || state == S_WAIT) begin
            tmr_en = 1'b1;
            if (tmr_done && state_nx == state) begin
                timeout  = 1'b1;
                state_nx = S_GAP;
            end
        end
`endif
        // Every state change restarts the shared timer.
        if (state_nx != state) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
`ifdef TMC_SPI_TIMEOUT_EN
            if (state_nx == S_LOAD || state_nx == S_WAIT) tmr_val = TMO_LD;
`endif
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            dgram      <= '0;
            phase      <= 1'b0;
            rsp_status <= '0;
            rsp_data   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dgram.wr   <= req_write_i;
                dgram.addr <= req_addr_i;
                dgram.data <= req_write_i ? req_data_i : 32'h0;
                phase      <= 1'b0;
            end
            if (state == S_WAIT && spi_do_valid_i) begin
                rsp_status <= spi_do_i[39:32];
                rsp_data   <= spi_do_i[31:0];
            end
            if (state == S_GAP && tmr_done && resend) begin
                phase <= 1'b1;
            end
`ifdef TMC_SPI_TIMEOUT_EN
            if (timeout) begin
                rsp_status <= '0;
                rsp_data   <= '0;
            end
`endif
        end
    end

`ifdef TMC_SPI_TIMEOUT_EN
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            abort <= 1'b0;
        end else if (accept) begin
            abort <= 1'b0;
        end else if (timeout) begin
            abort <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    tmc_spi_frame_timer #(
        .W(CW)
    ) u_timer (
        .clk      (pclk_i),
        .rst      (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    assign req_ready_o  = (state == S_IDLE);
    assign busy_o       = (state != S_IDLE);
    assign spi_wren_o   = (state == S_LOAD);
    assign rsp_valid_o  = (state == S_RESP);
    assign spi_di_o     = dgram;
    assign rsp_status_o = rsp_status;
    assign rsp_data_o   = rsp_data;
    assign rsp_error_o  = abort;

endmodule

// File: tb/tb_tmc_spi_sequencer.sv
// tb_tmc_spi_sequencer: randomized bench for tmc_spi_sequencer.
// Transaction-level model plus a simple SPI master stand-in.
module tb_tmc_spi_sequencer;

    localparam int GAP = 4;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [6:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_status_o;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    logic        busy_o;
    logic [39:0] spi_di_o;
    logic        spi_wren_o;
    logic        spi_wr_ack_i;
    logic        spi_do_valid_i;
    logic [39:0] spi_do_i;
    logic        spi_idle_i;

    int checks   = 0;
    int failures = 0;

    tmc_spi_sequencer #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk_i         (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_status_o   (rsp_status_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_error_o    (rsp_error_o),
        .busy_o         (busy_o),
        .spi_di_o       (spi_di_o),
        .spi_wren_o     (spi_wren_o),
        .spi_wr_ack_i   (spi_wr_ack_i),
        .spi_do_valid_i (spi_do_valid_i),
        .spi_do_i       (spi_do_i),
        .spi_idle_i     (spi_idle_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Transaction-level model: one outstanding request, frames still owed,
    // last reply seen, and consecutive idle cycles since that reply.
    bit          chk_en = 1'b1;
    bit          m_pend, m_await, m_post;
    int          m_left, m_run;
    logic [39:0] m_dg, m_reply;
    int          frames_acked = 0;
    int          rsp_seen = 0;

    always @(negedge clk) begin : cmp
        bit w_exp, r_exp, pend0;
        if (chk_en) begin
            if (rst_i) begin
                chk("rst_ready", 64'(req_ready_o), 64'(1));
                chk("rst_busy", 64'(busy_o), 64'(0));
                chk("rst_wren", 64'(spi_wren_o), 64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
                chk("rst_di", 64'(spi_di_o), 64'(0));
                chk("rst_rsp_data", 64'({rsp_status_o, rsp_data_o}), 64'(0));
                m_pend = 0; m_await = 0; m_post = 0; m_left = 0; m_run = 0;
            end else begin
                pend0 = m_pend;
                w_exp = m_pend && !m_await && m_left > 0 &&
                        (!m_post || m_run >= GAP);
                r_exp = m_pend && m_post && m_left == 0 && m_run >= GAP;
                chk("ready", 64'(req_ready_o), 64'(!m_pend));
                chk("busy", 64'(busy_o), 64'(m_pend));
                chk("wren", 64'(spi_wren_o), 64'(w_exp));
                chk("rsp_valid", 64'(rsp_valid_o), 64'(r_exp));
                chk("rsp_error", 64'(rsp_error_o), 64'(0));
                if (w_exp) chk("di", 64'(spi_di_o), 64'(m_dg));
                if (r_exp) chk("rsp_word", 64'({rsp_status_o, rsp_data_o}),
                               64'(m_reply));
                if (rsp_valid_o) rsp_seen++;
                if (r_exp) begin
                    m_pend = 0; m_post = 0;
                end else if (w_exp && spi_wr_ack_i) begin
                    m_await = 1; m_post = 0; m_left--; frames_acked++;
                end else if (m_await && spi_do_valid_i) begin
                    m_await = 0; m_post = 1; m_run = 0; m_reply = spi_do_i;
                end else if (m_post && m_run < GAP) begin
                    m_run = spi_idle_i ? m_run + 1 : 0;
                end
                if (!pend0 && req_valid_i) begin
                    m_pend  = 1; m_await = 0; m_post = 0;
                    m_left  = req_write_i ? 1 : 2;
                    m_dg    = {req_write_i, req_addr_i,
                               req_write_i ? req_data_i : 32'h0};
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit w, input logic [6:0] a, input logic [31:0] d);
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 100) begin cyc(); n++; end
        chk("req_ready_wait", 64'(req_ready_o), 64'(1));
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_data_i  = d;
        cyc();
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom);
        req_addr_i  = 7'($urandom);
        req_data_i  = $urandom;
    endtask

    task automatic serve_frame(input int ack_dly, input int flen, input int tail,
                               input bit noisy, input logic [39:0] reply,
                               output logic [39:0] sent);
        int n = 0;
        sent = '0;
        while (spi_wren_o !== 1'b1 && n < 200) begin cyc(); n++; end
        chk("frame_wren_wait", 64'(spi_wren_o), 64'(1));
        if (spi_wren_o !== 1'b1) return;
        repeat (ack_dly) cyc();
        sent = spi_di_o;
        spi_wr_ack_i = 1'b1;
        cyc();
        spi_wr_ack_i = 1'b0;
        spi_idle_i   = 1'b0;
        repeat (flen) begin
            spi_wr_ack_i = noisy && ($urandom_range(3, 0) == 0);
            cyc();
        end
        spi_wr_ack_i   = 1'b0;
        spi_do_i       = reply;
        spi_do_valid_i = 1'b1;
        cyc();
        spi_do_valid_i = 1'b0;
        repeat (tail) begin
            if (noisy) begin
                spi_do_valid_i = 1'($urandom);
                spi_do_i       = {8'($urandom), $urandom};
            end
            cyc();
        end
        spi_do_valid_i = 1'b0;
        spi_idle_i     = 1'b1;
        if (noisy && $urandom_range(1, 0) == 1) begin
            cyc();
            spi_idle_i = 1'b0;
            cyc();
            spi_idle_i = 1'b1;
        end
    endtask

    task automatic wait_rsp(output logic [7:0] st, output logic [31:0] dt);
        int n = 0;
        while (rsp_valid_o !== 1'b1 && n < 200) begin cyc(); n++; end
        chk("rsp_arrives", 64'(rsp_valid_o), 64'(1));
        st = rsp_status_o;
        dt = rsp_data_o;
        cyc();
    endtask

    initial begin
        logic [39:0] s0, s1, r0, r1, ex;
        logic [7:0]  st;
        logic [31:0] dt, d;
        logic [6:0]  a;
        bit          w;
        int          n, fa, rs;

        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0;
        req_addr_i = '0; req_data_i = '0; spi_wr_ack_i = 1'b0;
        spi_do_valid_i = 1'b0; spi_do_i = '0; spi_idle_i = 1'b1;
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();
        chk("reset_ready", 64'(req_ready_o), 64'(1));
        chk("reset_busy", 64'(busy_o), 64'(0));

        fa = frames_acked; rs = rsp_seen;
        send_req(1'b1, 7'h21, 32'h0000_1234);
        serve_frame(2, 4, 2, 1'b0, 40'h05_DEAD_BEEF, s0);
        wait_rsp(st, dt);
        chk("wr_dgram", 64'(s0), 64'(40'hA1_0000_1234));
        chk("wr_status", 64'(st), 64'(8'h05));
        chk("wr_data", 64'(dt), 64'(32'hDEAD_BEEF));
        chk("wr_frames", 64'(frames_acked - fa), 64'(1));
        chk("wr_rsp_count", 64'(rsp_seen - rs), 64'(1));
        chk("wr_rsp_hold", 64'(rsp_data_o), 64'(32'hDEAD_BEEF));

        fa = frames_acked;
        send_req(1'b0, 7'h6F, 32'h5555_AAAA);
        serve_frame(0, 3, 1, 1'b0, 40'h77_1111_2222, s0);
        serve_frame(1, 5, 1, 1'b0, 40'h01_CAFE_0001, s1);
        wait_rsp(st, dt);
        chk("rd_dgram0", 64'(s0), 64'(40'h6F_0000_0000));
        chk("rd_dgram1", 64'(s1), 64'(40'h6F_0000_0000));
        chk("rd_status", 64'(st), 64'(8'h01));
        chk("rd_data", 64'(dt), 64'(32'hCAFE_0001));
        chk("rd_frames", 64'(frames_acked - fa), 64'(2));

        send_req(1'b0, 7'h15, 32'h0);
        serve_frame(0, 3, 20, 1'b0, 40'h02_0000_0015, s0);
        n = 0;
        while (spi_wren_o !== 1'b1 && n < 50) begin cyc(); n++; end
        chk("gap_wren_delay", 64'(n), 64'(GAP));
        serve_frame(0, 2, 0, 1'b0, 40'h03_1234_5678, s1);
        wait_rsp(st, dt);
        chk("gap_rd_data", 64'(dt), 64'(32'h1234_5678));

        send_req(1'b0, 7'h33, 32'h0);
        chk("load_wren", 64'(spi_wren_o), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_load_wren", 64'(spi_wren_o), 64'(0));
        chk("rst_load_busy", 64'(busy_o), 64'(0));
        cyc();
        rst_i = 1'b0;
        cyc();

        rs = rsp_seen;
        send_req(1'b0, 7'h44, 32'h0);
        spi_wr_ack_i = 1'b1;
        cyc();
        spi_wr_ack_i = 1'b0;
        spi_idle_i   = 1'b0;
        cyc();
        chk("wait_busy", 64'(busy_o), 64'(1));
        rst_i = 1'b1;
        #1;
        chk("rst_wait_busy", 64'(busy_o), 64'(0));
        chk("rst_wait_wren", 64'(spi_wren_o), 64'(0));
        cyc();
        rst_i = 1'b0;
        cyc();
        spi_do_i = 40'h0A_BAD0_BAD0;
        spi_do_valid_i = 1'b1;
        cyc();
        spi_do_valid_i = 1'b0;
        spi_idle_i = 1'b1;
        repeat (10) cyc();
        chk("late_rx_no_rsp", 64'(rsp_seen - rs), 64'(0));
        chk("late_rx_ready", 64'(req_ready_o), 64'(1));

        send_req(1'b1, 7'h00, 32'hFFFF_0001);
        serve_frame(1, 3, 0, 1'b0, 40'h0F_0000_00AA, s0);
        wait_rsp(st, dt);
        chk("post_rst_dgram", 64'(s0), 64'(40'h80_FFFF_0001));
        chk("post_rst_data", 64'({st, dt}), 64'(40'h0F_0000_00AA));

        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom);
            a = 7'($urandom);
            d = $urandom;
            ex = {w, a, w ? d : 32'h0};
            r0 = {8'($urandom), $urandom};
            r1 = {8'($urandom), $urandom};
            send_req(w, a, d);
            serve_frame($urandom_range(3, 0), $urandom_range(6, 2),
                        $urandom_range(3, 0), 1'b1, r0, s0);
            chk("rand_dgram0", 64'(s0), 64'(ex));
            if (!w) begin
                serve_frame($urandom_range(3, 0), $urandom_range(6, 2),
                            $urandom_range(3, 0), 1'b1, r1, s1);
                chk("rand_dgram1", 64'(s1), 64'(ex));
            end
            wait_rsp(st, dt);
            chk("rand_rsp", 64'({st, dt}), 64'(w ? r0 : r1));
        end

`ifdef TMC_SPI_TIMEOUT_EN
        chk_en = 1'b0;
        send_req(1'b0, 7'h10, 32'h0);
        n = 1;
        while (rsp_valid_o !== 1'b1 && n < 60) begin cyc(); n++; end
        chk("to_rsp_valid", 64'(rsp_valid_o), 64'(1));
        chk("to_latency_ok", 64'(n <= 16 + GAP + 3), 64'(1));
        chk("to_latency_min", 64'(n >= 16), 64'(1));
        chk("to_error", 64'(rsp_error_o), 64'(1));
        chk("to_data", 64'({rsp_status_o, rsp_data_o}), 64'(0));
        chk("to_wren", 64'(spi_wren_o), 64'(0));
        cyc();
        chk("to_ready", 64'(req_ready_o), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmc_spi_sequencer.md
# tmc_spi_sequencer

Register-access sequencer for the TMC5130 driver. Sits directly upstream of the 40-bit SPI master wrapper. Converts single register read/write requests into 40-bit TMC5130 datagrams and drives the master's `di_i`/`wren_i` handshake. Hides the chip's pipelined read (the reply arrives on the next frame) and returns one response per request: status byte plus 32-bit data.

## Interface
Parameters:
- `GAP_CYCLES`, 4: minimum `pclk_i` cycles between frames, counted after `spi_idle_i` is high; guarantees CSN high time. Range 1..255.
- `TIMEOUT_CYCLES`, 4095: cycles to wait for `spi_do_valid_i` before aborting (used only with `TMC_SPI_TIMEOUT_EN`).

Ports:
- `pclk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_write_i` in 1: 1 = register write, 0 = read.
- `req_addr_i` in 7: TMC5130 register address.
- `req_data_i` in 32: write data; ignored for reads.
- `rsp_valid_o` out 1: one-cycle response pulse; no backpressure.
- `rsp_status_o` out 8: SPI_STATUS byte (`do[39:32]`) of the frame that carries the result.
- `rsp_data_o` out 32: result data (`do[31:0]`).
- `rsp_error_o` out 1: timeout abort.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `spi_di_o` out 40: datagram to the master.
- `spi_wren_o` out 1: write strobe to the master.
- `spi_wr_ack_i` in 1: master accepted `spi_di_o`.
- `spi_do_valid_i` in 1: master received frame, `spi_do_i` valid this cycle.
- `spi_do_i` in 40: received frame.
- `spi_idle_i` in 1: master idle (CSN deasserted).

## Operation
- Datagram format: `{req_write_i, req_addr_i, data}`. For reads the data field is 32'h0.
- States: IDLE, LOAD, WAIT_RX, GAP, RESP.
- A `phase` bit selects between the first frame and the second (read) frame.
- IDLE:
  - `req_ready_o` = 1.
  - On accept, register the datagram and clear `phase`, then go to LOAD.
- LOAD:
  - `spi_wren_o` = 1 and `spi_di_o` is held stable.
  - On `spi_wr_ack_i` = 1, go to WAIT_RX. `spi_wren_o` drops the following cycle.
- WAIT_RX:
  - On `spi_do_valid_i`, capture `spi_do_i` into the response register, then go to GAP.
- GAP:
  - The counter runs only while `spi_idle_i` = 1; `GAP_CYCLES` consecutive idle cycles end the state.
  - Exit to LOAD if this is a read with `phase` = 0. Set `phase` = 1 and resend the identical read datagram.
  - Otherwise exit to RESP.
- RESP:
  - `rsp_valid_o` = 1 for exactly one cycle, then go to IDLE.
- Writes take one frame; the returned data is the previous pipelined read value and is passed through unchanged.
- Reads take two frames; the response comes from the second frame.
- `spi_do_valid_i` outside WAIT_RX is ignored.
- `spi_wr_ack_i` outside LOAD is ignored.
- Reset values: all outputs 0 except `req_ready_o` = 1 (IDLE). `spi_di_o` = 0, response registers = 0.
- Reset mid-frame: the FSM returns to IDLE immediately and `spi_wren_o` drops asynchronously. A frame already in flight in the master completes and its `do_valid` is ignored.

## Timing
- Accept at cycle 0 -> `spi_wren_o` high from cycle 1.
- `req_ready_o` is low from cycle 1 until the cycle after `rsp_valid_o`.
- Back-to-back requests: the next accept is possible one cycle after `rsp_valid_o`.
- Write latency = ack wait + frame + `GAP_CYCLES` + 2. A read adds a second LOAD/WAIT_RX/GAP sequence.
- `rsp_*` registers are stable from `rsp_valid_o` until the next accept.

## Configuration
- `TMC_SPI_TIMEOUT_EN` defined:
  - A counter runs in LOAD and WAIT_RX.
  - Reaching `TIMEOUT_CYCLES` without ack/valid drops `spi_wren_o`, sets `rsp_error_o`, zeroes `rsp_data_o` and `rsp_status_o`, then goes to GAP -> RESP. No second frame is sent.
  - The counter clears on every state change.
- Not defined:
  - No counter is built and `rsp_error_o` is tied 0.
  - The FSM waits indefinitely.

## Structure
- Package `tmc_spi_pkg`:
  - `TMC_DGRAM_W` = 40.
  - `tmc_dgram_t` packed struct: `wr`, `addr[6:0]`, `data[31:0]`.
  - `tmc_seq_state_e` enum.
- Sub-module `tmc_spi_frame_timer`: a loadable down-counter with enable and done flag. It is shared by the GAP count and the timeout, which are never active simultaneously.

## Test plan
- Write addr 7'h21, data 32'h0000_1234 -> `spi_di_o` = 40'hA1_0000_1234 held until ack. One frame. `rsp_valid_o` once, with status/data equal to the bench's returned 40'h05_DEAD_BEEF.
- Read addr 7'h6F -> two frames, both 40'h6F_0000_0000. `rsp_data_o` comes from the second reply (40'h01_CAFE_0001 -> data 32'hCAFE_0001, status 8'h01).
- Hold `spi_idle_i` low 20 cycles after `do_valid` with `GAP_CYCLES` = 4 -> next `spi_wren_o` rises no earlier than 4 cycles after `spi_idle_i` rises.
- Assert `rst_i` during WAIT_RX -> `spi_wren_o`/`busy_o` = 0 immediately. Late `spi_do_valid_i` produces no `rsp_valid_o`. Next request works normally.
- With `TMC_SPI_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, never ack -> `rsp_valid_o` with `rsp_error_o` = 1 and data 0 within 16 + `GAP_CYCLES` + 3 cycles, then `req_ready_o` = 1.
